// File: rtl/prod_bcd_pkg.sv
// Shared constants, state encoding and add-3 helper for the product BCD converter.
// Latency: none (package only).
// Backpressure: none (package only).
package prod_bcd_pkg;

  // Default geometry: 8-bit product, three BCD digits (0..255 fits in 000..999)
  localparam int W_DEF  = 8;
  localparam int ND_DEF = 3;

  // BCD nibble width and the double-dabble correction threshold
  localparam int         NIB_W   = 4;
  localparam logic [3:0] ADD3_TH = 4'd5;

  // Converter FSM encoding
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Active-low seven-segment codes, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Nibble-local correction: a digit of 5 or more would exceed 9 after doubling,
  // so pre-add 3 to force the carry into the next nibble on the shift.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= ADD3_TH) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment (gfedcba) decoder.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows input.
module bcd_to_seg7
  import prod_bcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digit lookup; non-decimal nibbles blank the display
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/prod_bcd_conv.sv
// Sequential double-dabble converter: multiplier product -> packed BCD digits (+ optional 7-seg when PROD_BCD_SEG_EN is defined).
// Latency: W cycles from the edge sampling start to the valid pulse; one conversion per W+1 cycles.
// Backpressure: none; start is only honoured in IDLE and is dropped while busy (no queuing).
module prod_bcd_conv
  import prod_bcd_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int ND = ND_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      bin_in,
  input  logic              start,
`ifdef PROD_BCD_SEG_EN
  output logic [7*ND-1:0]   seg_o,
`endif
  output logic [4*ND-1:0]   bcd_out,
  output logic              valid,
  output logic              busy
);

  localparam int BW = NIB_W * ND;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t          state;
  state_t          state_nxt;
  logic [BW-1:0]   bcd_acc;
  logic [W-1:0]    bin_sh;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   acc_adj;
  logic [BW+W-1:0] work_sh;
  logic [BW-1:0]   acc_nxt;
  logic [W-1:0]    bin_nxt;
  logic            last;

  // Add-3 every accumulator nibble, then shift the whole working register left by one
  always_comb begin
    acc_adj = '0;
    for (int i = 0; i < ND; i++) begin
      acc_adj[i*NIB_W +: NIB_W] = add3(bcd_acc[i*NIB_W +: NIB_W]);
    end
    work_sh = {acc_adj, bin_sh} << 1;
    acc_nxt = work_sh[BW+W-1:W];
    bin_nxt = work_sh[W-1:0];
    last    = (state == ST_SHIFT) && (cnt == CW'(W - 1));
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: IDLE waits for start, SHIFT runs W iterations
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last)  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: busy covers the SHIFT state only, so it drops in the valid cycle
  always_comb begin
    busy = (state == ST_SHIFT);
  end

  // Working register and iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_acc <= '0;
      bin_sh  <= '0;
      cnt     <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        bcd_acc <= '0;
        bin_sh  <= bin_in;
        cnt     <= '0;
      end
    end else begin
      bcd_acc <= acc_nxt;
      bin_sh  <= bin_nxt;
      cnt     <= cnt + CW'(1);
    end
  end

  // Result register and single-cycle valid pulse; result holds until the next completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= last;
      if (last) bcd_out <= acc_nxt;
    end
  end

`ifdef PROD_BCD_SEG_EN
  logic [7*ND-1:0] seg_nxt;

  // Decode the final accumulator so the segments land on the same edge as bcd_out
  for (genvar g = 0; g < ND; g++) begin : g_seg
    bcd_to_seg7 u_seg (
      .bcd (acc_nxt[g*NIB_W +: NIB_W]),
      .seg (seg_nxt[g*7 +: 7])
    );
  end

  // Registered segment outputs, blank out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       seg_o <= '1;
    else if (last) seg_o <= seg_nxt;
  end
`endif

endmodule

// File: tb/tb_prod_bcd_conv.sv
// Scoreboard bench for prod_bcd_conv: expected BCD pushed on each accepted start, popped on valid.
// Latency: checks the W-cycle start-to-valid timing and busy profile.
// Backpressure: exercises starts during busy (dropped) and during valid (accepted).
module tb_prod_bcd_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;
  logic [11:0] bcd_out;
  logic        valid;
  logic        busy;
`ifdef PROD_BCD_SEG_EN
  logic [20:0] seg_o;
`endif

  int          total = 0;
  int          bad   = 0;
  int          pushes = 0;
  int          pulses = 0;
  logic        prev_valid = 1'b0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  prod_bcd_conv #(.W(8), .ND(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bin_in),
    .start   (start),
`ifdef PROD_BCD_SEG_EN
    .seg_o   (seg_o),
`endif
    .bcd_out (bcd_out),
    .valid   (valid),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference conversion by plain decimal arithmetic
  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Output monitor: every valid pops one expected result
  always @(negedge clk) begin : mon
    logic [11:0] want;
    if (valid) begin
      pulses++;
      chk("valid_single", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        want = exp_q.pop_front();
        chk("bcd_out", {20'd0, bcd_out}, {20'd0, want});
`ifdef PROD_BCD_SEG_EN
        chk("seg_o", {11'd0, seg_o},
            {11'd0, seg7(want[11:8]), seg7(want[7:4]), seg7(want[3:0])});
`endif
      end
    end
    prev_valid = valid;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive start for one edge (edge k); returns #1 after edge k
  task automatic launch(input logic [7:0] v, input bit expect_result);
    bin_in = v;
    start  = 1'b1;
    if (expect_result) begin
      exp_q.push_back(to_bcd(int'(v)));
      pushes++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_start", {31'd0, busy}, 32'd1);
  endtask

  // Wait for valid, n0 edges already elapsed since edge k; valid must follow edge k+8
  task automatic wait_valid(input int n0);
    int n;
    n = n0;
    while (!valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 32'd8);
    chk("busy_in_valid", {31'd0, busy}, 32'd0);
  endtask

  task automatic conv(input logic [7:0] v);
    launch(v, 1'b1);
    wait_valid(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 8'd0;
    idle(3);
    chk("rst_bcd_out", {20'd0, bcd_out}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef PROD_BCD_SEG_EN
    chk("rst_seg", {11'd0, seg_o}, {11'd0, 21'h1FFFFF});
`endif
    rst = 1'b0;
    idle(2);

    // Directed products and boundaries
    conv(8'h0E); idle(3);
    conv(8'h2D); idle(2);
    conv(8'd0);  idle(2);
    conv(8'd255); idle(2);
    for (int i = 0; i < 4; i++) begin
      conv(8'($urandom_range(0, 255)));
      idle(1);
    end

    // Start at cycle 3 of a conversion is dropped
    launch(8'd14, 1'b1);
    idle(2);
    bin_in = 8'd99;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ignored", {31'd0, busy}, 32'd1);
    wait_valid(3);

    // Start during the valid cycle is accepted immediately
    launch(8'd99, 1'b1);
    wait_valid(0);
    idle(12);

    // Reset at cycle 4 of a conversion discards it
    launch(8'd45, 1'b0);
    idle(3);
    rst = 1'b1;
    #1;
    chk("midrst_bcd_out", {20'd0, bcd_out}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    idle(2);
    rst = 1'b0;
    idle(12);
    conv(8'd7);

    idle(3);
    chk("pulse_count", pulses, pushes);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
